gf7_divider: RTL



---
 rtl/gf7_divider.sv | 138 +++++++++++++
 1 files changed

// File: rtl/gf7_divider.sv
// Sequential GF(2^7) divider, q = a * b^-1 mod x^7 + x + 1.
// One shared field multiplier computes b^126 by square-and-multiply, then a * b^126.
module gf7_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] a,
  input  logic [6:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] q,
  output logic       div_by_zero,
  output logic       busy
);

  typedef enum logic [2:0] {StIdle, StSqr, StMul, StFin, StDone} state_e;

  state_e     state_q, state_d;
  logic [6:0] a_q, a_d;
  logic [6:0] t_q, t_d;
  logic [6:0] r_q, r_d;
  logic [2:0] round_q, round_d;
  logic [6:0] q_q, q_d;
  logic       out_valid_q, out_valid_d;
  logic       dbz_q, dbz_d;

  logic [6:0] mul_x, mul_y, prod;

  function automatic logic [6:0] gf_mul(input logic [6:0] x, input logic [6:0] y);
    logic [12:0] s;
    logic [6:0]  c;
    s = '0;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 7; j++) begin
        s[i+j] = s[i+j] ^ (x[i] & y[j]);
      end
    end
    // x^7 folds back onto x + 1
    c[0] = s[0] ^ s[7];
    for (int k = 1; k < 6; k++) begin
      c[k] = s[k] ^ s[k+6] ^ s[k+7];
    end
    c[6] = s[6] ^ s[12];
    return c;
  endfunction

  always_comb begin
    mul_x = t_q;
    mul_y = t_q;
    case (state_q)
      StMul: mul_x = r_q;
      StFin: begin
        mul_x = a_q;
        mul_y = r_q;
      end
      default: ;
    endcase
    prod = gf_mul(mul_x, mul_y);
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    t_d         = t_q;
    r_d         = r_q;
    round_d     = round_q;
    q_d         = q_q;
    out_valid_d = out_valid_q;
    dbz_d       = dbz_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          t_d     = b;
          r_d     = 7'h01;
          round_d = 3'd1;
          dbz_d   = (b == 7'h00);
          state_d = StSqr;
        end
      end
      StSqr: begin
        t_d     = prod;
        state_d = StMul;
      end
      StMul: begin
        r_d = prod;
        if (round_q == 3'd6) begin
          state_d = StFin;
        end else begin
          round_d = round_q + 3'd1;
          state_d = StSqr;
        end
      end
      StFin: begin
        q_d         = prod;
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      t_q         <= '0;
      r_q         <= '0;
      round_q     <= '0;
      q_q         <= '0;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      t_q         <= t_d;
      r_q         <= r_d;
      round_q     <= round_d;
      q_q         <= q_d;
      out_valid_q <= out_valid_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign out_valid   = out_valid_q;
  assign q           = q_q;
  assign div_by_zero = dbz_q;

endmodule
